pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake on both sides.
// Holds one main entry that drives out_*. With SKID_EN=1 a second skid entry
// absorbs one accept made while downstream stalls, so in_ready depends only on
// registered state. With SKID_EN=0 the stage is a single register whose in_ready
// passes out_ready through combinationally.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned SKID_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [RADDR_W-1:0] in_regaddr,
  input  logic               in_regwrite,
  output logic               out_valid,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic [DATA_W-1:0]  out_data,
  output logic [RADDR_W-1:0] out_regaddr,
  output logic               out_regwrite,
  input  logic               out_ready,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One entry is packed as {instr, pc, data, regaddr, regwrite}.
  localparam int unsigned ENT_W = 32 + 32 + DATA_W + RADDR_W + 1;

  state_t           state_q, state_d;
  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] main_q, main_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             main_regwrite;
  logic             accept;
  logic             emit;

  assign in_ent = {in_instr, in_pc, in_data, in_regaddr, in_regwrite};

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID_EN != 0) ? (state_q != FULL)
                                    : ((state_q == EMPTY) || out_ready);

  // An entry offered during a flush is dropped, never counted as accepted.
  assign accept = in_valid && in_ready && !flush;
  assign emit   = out_valid && out_ready;

  assign {out_instr, out_pc, out_data, out_regaddr, main_regwrite} = main_q;
  assign out_regwrite = main_regwrite && out_valid;
  assign occupancy    = 2'(state_q);

  // Next-state and next-payload selection; payloads are cleared whenever the
  // stage is about to become empty.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_ent;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_d = in_ent;
          end else if (accept && (SKID_EN != 0)) begin
            state_d = FULL;
            skid_d  = in_ent;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    if (state_d == EMPTY) begin
      main_d = '0;
      skid_d = '0;
    end
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (DATA_W=64) and a single-entry
// instance (SKID_EN=0), each compared every cycle against a queue model, plus
// directed sequences with literal expectations.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] data;
    logic [4:0]  ra;
    logic        rw;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  // Instance A: SKID_EN=1, DATA_W=64
  logic        a_in_valid, a_in_ready, a_in_regwrite, a_out_valid, a_out_regwrite, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc;
  logic [63:0] a_in_data, a_out_data;
  logic [4:0]  a_in_regaddr, a_out_regaddr;
  logic [1:0]  a_occ;

  // Instance B: SKID_EN=0, DATA_W=32
  logic        b_in_valid, b_in_ready, b_in_regwrite, b_out_valid, b_out_regwrite, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_regaddr, b_out_regaddr;
  logic [1:0]  b_occ;

  ent_t qa[$];
  ent_t qb[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .RADDR_W(5), .SKID_EN(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .in_data(a_in_data),
    .in_regaddr(a_in_regaddr), .in_regwrite(a_in_regwrite),
    .out_valid(a_out_valid), .out_instr(a_out_instr), .out_pc(a_out_pc),
    .out_data(a_out_data), .out_regaddr(a_out_regaddr), .out_regwrite(a_out_regwrite),
    .out_ready(a_out_ready), .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_W(32), .RADDR_W(5), .SKID_EN(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .in_data(b_in_data),
    .in_regaddr(b_in_regaddr), .in_regwrite(b_in_regwrite),
    .out_valid(b_out_valid), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .out_data(b_out_data), .out_regaddr(b_out_regaddr), .out_regwrite(b_out_regwrite),
    .out_ready(b_out_ready), .occupancy(b_occ)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare both DUTs against their queue models (head of queue drives outputs).
  task automatic check_all();
    ent_t h;
    bit   v;
    v = (qa.size() > 0);
    h = v ? qa[0] : '0;
    chk("a_out_valid", 64'(a_out_valid), 64'(v));
    chk("a_in_ready",  64'(a_in_ready),  64'(qa.size() < 2));
    chk("a_occupancy", 64'(a_occ),       64'(qa.size()));
    chk("a_out_instr", 64'(a_out_instr), 64'(h.instr));
    chk("a_out_pc",    64'(a_out_pc),    64'(h.pc));
    chk("a_out_data",  a_out_data,       h.data);
    chk("a_out_regaddr", 64'(a_out_regaddr), 64'(h.ra));
    chk("a_out_regwrite", 64'(a_out_regwrite), 64'(h.rw & v));
    v = (qb.size() > 0);
    h = v ? qb[0] : '0;
    chk("b_out_valid", 64'(b_out_valid), 64'(v));
    chk("b_in_ready",  64'(b_in_ready),  64'(qb.size() == 0 || b_out_ready));
    chk("b_occupancy", 64'(b_occ),       64'(qb.size()));
    chk("b_out_instr", 64'(b_out_instr), 64'(h.instr));
    chk("b_out_pc",    64'(b_out_pc),    64'(h.pc));
    chk("b_out_data",  64'(b_out_data),  64'(h.data[31:0]));
    chk("b_out_regaddr", 64'(b_out_regaddr), 64'(h.ra));
    chk("b_out_regwrite", 64'(b_out_regwrite), 64'(h.rw & v));
  endtask

  // Called at a negedge with inputs set: advance one clock, update models, check.
  task automatic tick();
    bit   acc_a, emit_a, acc_b, emit_b;
    ent_t ea, eb;
    acc_a  = a_in_valid && (qa.size() < 2) && !flush;
    emit_a = (qa.size() > 0) && a_out_ready;
    acc_b  = b_in_valid && (qb.size() == 0 || b_out_ready) && !flush;
    emit_b = (qb.size() > 0) && b_out_ready;
    ea = '{a_in_instr, a_in_pc, a_in_data, a_in_regaddr, a_in_regwrite};
    eb = '{b_in_instr, b_in_pc, 64'(b_in_data), b_in_regaddr, b_in_regwrite};
    @(posedge clk);
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (emit_a) void'(qa.pop_front());
      if (acc_a)  qa.push_back(ea);
      if (emit_b) void'(qb.pop_front());
      if (acc_b)  qb.push_back(eb);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    flush = 0;
    a_in_valid = 0; a_in_instr = '0; a_in_pc = '0; a_in_data = '0;
    a_in_regaddr = '0; a_in_regwrite = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_instr = '0; b_in_pc = '0; b_in_data = '0;
    b_in_regaddr = '0; b_in_regwrite = 0; b_out_ready = 1;
  endtask

  task automatic push_a(input logic [31:0] pc, input logic rdy);
    a_in_valid = 1; a_in_pc = pc; a_in_instr = ~pc; a_in_regwrite = 1;
    a_in_regaddr = 5'd7; a_in_data = {32'h0, pc};
    a_out_ready = rdy;
  endtask

  task automatic rand_inputs();
    flush = ($urandom_range(0, 15) == 0);
    a_in_valid = $urandom_range(0, 3) != 0;
    a_in_instr = $urandom; a_in_pc = $urandom; a_in_data = {$urandom, $urandom};
    a_in_regaddr = 5'($urandom); a_in_regwrite = 1'($urandom);
    a_out_ready = $urandom_range(0, 2) != 0;
    b_in_valid = $urandom_range(0, 3) != 0;
    b_in_instr = $urandom; b_in_pc = $urandom; b_in_data = $urandom;
    b_in_regaddr = 5'($urandom); b_in_regwrite = 1'($urandom);
    b_out_ready = $urandom_range(0, 2) != 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_in_ready_a", 64'(a_in_ready), 64'd1);
    reset = 0;
    @(negedge clk);
    check_all();

    // Single accept with 1-cycle latency
    push_a(32'h3000, 1);
    tick();
    chk("r33_valid", 64'(a_out_valid), 64'd1);
    chk("r33_pc", 64'(a_out_pc), 64'h3000);
    chk("r33_regwrite", 64'(a_out_regwrite), 64'd1);
    chk("r33_occ", 64'(a_occ), 64'd1);
    a_in_valid = 0;
    tick();

    // Fill skid while stalled, drain in order
    push_a(32'h3000, 0); tick();
    push_a(32'h3004, 0); tick();
    chk("r34_occ2", 64'(a_occ), 64'd2);
    chk("r34_ready0", 64'(a_in_ready), 64'd0);
    a_in_valid = 0; a_out_ready = 1;
    chk("r34_head0", 64'(a_out_pc), 64'h3000);
    tick();
    chk("r34_occ1", 64'(a_occ), 64'd1);
    chk("r34_head1", 64'(a_out_pc), 64'h3004);
    tick();
    chk("r34_occ0", 64'(a_occ), 64'd0);

    // Flush while FULL drops the offered entry
    push_a(32'h3000, 0); tick();
    push_a(32'h3004, 0); tick();
    push_a(32'h3008, 1); flush = 1;
    tick();
    chk("r35_occ", 64'(a_occ), 64'd0);
    chk("r35_valid", 64'(a_out_valid), 64'd0);
    chk("r35_pc", 64'(a_out_pc), 64'd0);
    flush = 0; a_in_valid = 0;
    repeat (2) tick();

    // Asynchronous reset between edges while FULL
    push_a(32'h4000, 0); tick();
    push_a(32'h4004, 0); tick();
    chk("r36_full", 64'(a_occ), 64'd2);
    a_in_valid = 0;
    #2 reset = 1;
    #1;
    chk("r36_valid", 64'(a_out_valid), 64'd0);
    chk("r36_regwrite", 64'(a_out_regwrite), 64'd0);
    chk("r36_ready", 64'(a_in_ready), 64'd1);
    chk("r36_occ", 64'(a_occ), 64'd0);
    qa.delete(); qb.delete();
    @(negedge clk);
    reset = 0;
    check_all();

    // Single-entry mode: combinational in_ready from out_ready
    b_in_valid = 1; b_in_pc = 32'h100; b_out_ready = 0;
    tick();
    chk("r37_occ1", 64'(b_occ), 64'd1);
    b_in_pc = 32'h104;
    #1 chk("r37_ready0", 64'(b_in_ready), 64'd0);
    b_out_ready = 1;
    #1 chk("r37_ready1", 64'(b_in_ready), 64'd1);
    tick();
    chk("r37_occ_stay", 64'(b_occ), 64'd1);
    chk("r37_pc", 64'(b_out_pc), 64'h104);
    b_in_valid = 0;
    tick();

    // Wide data path
    push_a(32'h5000, 1); a_in_data = 64'hDEADBEEF_01234567;
    tick();
    chk("r38_data", a_out_data, 64'hDEADBEEF_01234567);
    a_in_valid = 0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
